// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_pkg
//  Description : Shared instruction constants and helpers for the load/store
//                path. The LDW/SDW values mirror the shared def.v opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

   localparam logic [5:0] c_OP_ADD = 6'h00;
   localparam logic [5:0] c_OP_LDW = 6'h23;
   localparam logic [5:0] c_OP_SDW = 6'h2B;

   // True for the only two opcodes that touch data memory
   function automatic logic f_is_mem_op(input logic [5:0] op);
      return (op == c_OP_LDW) || (op == c_OP_SDW);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : access_timeout_counter
//  Description : Counts request cycles that go by without an acknowledge.
//                expired flags the cycle in which the count reaches TIMEOUT,
//                so the owner can abort on that same edge and mem_req stays
//                high for exactly TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module access_timeout_counter #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int c_CNT_W = $clog2(TIMEOUT + 1);

   logic [c_CNT_W-1:0] r_count;
   logic [c_CNT_W-1:0] w_count_next;

   assign w_count_next = r_count + c_CNT_W'(1);
   assign expired      = enable && (w_count_next == c_CNT_W'(TIMEOUT));

   // Clear has priority so a fresh access always starts from zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= w_count_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Executes LDW/SDW data-memory accesses over a req/ack
//                handshake, stalls the pipeline while outstanding, and
//                reports completion (done) or failure (err) with pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [5:0]        opcode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_ACCESS = 2'd1;
   localparam logic [1:0] c_ST_DONE   = 2'd2;

   logic [1:0]        r_state;
   logic              r_err;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

   logic w_mem_op;
   logic w_accept;
   logic w_misalign;
   logic w_in_access;
   logic w_expired;

   assign w_mem_op    = start && f_is_mem_op(opcode);
   assign w_accept    = (r_state == c_ST_IDLE) && w_mem_op && (addr[1:0] == 2'b00);
   assign w_misalign  = (r_state == c_ST_IDLE) && w_mem_op && (addr[1:0] != 2'b00);
   assign w_in_access = (r_state == c_ST_ACCESS);

   access_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_accept),
      .enable  (w_in_access && !mem_ack),
      .expired (w_expired)
   );

   // Access sequencing: latch the request, wait for ack or timeout, then retire
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_we    <= (opcode == c_OP_SDW);
                  r_state <= c_ST_ACCESS;
               end else if (w_misalign) begin
                  r_err <= 1'b1;
               end
            end
            c_ST_ACCESS: begin
               // Ack wins over an expiry landing in the same cycle
               if (mem_ack) begin
                  if (!r_we) begin
                     r_rdata <= mem_rdata;
                  end
                  r_state <= c_ST_DONE;
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_state <= c_ST_IDLE;
               end
            end
            c_ST_DONE: begin
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (r_state != c_ST_IDLE);
   assign done      = (r_state == c_ST_DONE);
   assign err       = r_err;
   assign mem_req   = w_in_access;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. Each instruction is
//                turned into an expected timeline (request length, outcome,
//                resulting load data) and the DUT is compared cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [5:0]        opcode;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rdata;
   logic              err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   int                n_checks = 0;
   int                n_errors = 0;
   logic [DATA_W-1:0] exp_rdata = '0;

   always #5 clk = ~clk;

   mem_access_unit #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .opcode    (opcode),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Quiet-bus expectations: nothing outstanding, no pulses, load data held
   task automatic check_quiet(input string tag);
      check({tag, ".busy"},    busy,    0);
      check({tag, ".mem_req"}, mem_req, 0);
      check({tag, ".done"},    done,    0);
      check({tag, ".err"},     err,     0);
      check({tag, ".rdata"},   rdata,   exp_rdata);
   endtask

   // Idle cycles with random acks on the bus, which must be ignored
   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         start     = 1'b0;
         mem_ack   = 1'($urandom_range(1));
         mem_rdata = $urandom;
         @(negedge clk);
         check_quiet("idle");
      end
      mem_ack = 1'b0;
   endtask

   // One instruction presented at the current negedge. ack_wait is the number
   // of request cycles without ack before ack arrives (>= TIMEOUT: never).
   // hold keeps start asserted throughout, as a stalled pipeline would.
   task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_wait, input logic [31:0] rd_val, input bit hold);
      bit is_mem  = (op == c_OP_LDW) || (op == c_OP_SDW);
      bit aligned = (a[1:0] == 2'b00);
      bit acked   = (ack_wait < TIMEOUT);
      int n_req   = acked ? ack_wait + 1 : TIMEOUT;
      start   = 1'b1;
      opcode  = op;
      addr    = a;
      wdata   = wd;
      mem_ack = 1'b0;
      @(posedge clk);
      if (!is_mem) begin
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_quiet("nonmem");
            start = 1'b0;
         end
      end else if (!aligned) begin
         @(negedge clk);
         check("mis.err",     err,     1);
         check("mis.busy",    busy,    0);
         check("mis.mem_req", mem_req, 0);
         check("mis.done",    done,    0);
         start = 1'b0;
         @(negedge clk);
         check_quiet("mis.after");
      end else begin
         for (int k = 1; k <= n_req; k++) begin
            @(negedge clk);
            check("acc.mem_req",   mem_req,   1);
            check("acc.busy",      busy,      1);
            check("acc.done",      done,      0);
            check("acc.err",       err,       0);
            check("acc.mem_we",    mem_we,    (op == c_OP_SDW));
            check("acc.mem_addr",  mem_addr,  a);
            check("acc.mem_wdata", mem_wdata, wd);
            start     = hold;
            mem_ack   = acked && (k == n_req);
            mem_rdata = mem_ack ? rd_val : $urandom;
         end
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (acked) begin
            if (op == c_OP_LDW) exp_rdata = rd_val;
            check("fin.done",    done,    1);
            check("fin.busy",    busy,    1);
            check("fin.mem_req", mem_req, 0);
            check("fin.err",     err,     0);
            check("fin.rdata",   rdata,   exp_rdata);
            @(negedge clk);
            check_quiet("fin.after");
         end else begin
            check("tmo.err",     err,     1);
            check("tmo.busy",    busy,    0);
            check("tmo.mem_req", mem_req, 0);
            check("tmo.done",    done,    0);
            check("tmo.rdata",   rdata,   exp_rdata);
         end
      end
      start = hold;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [5:0]  ops [4];
      logic [31:0] ra;
      ops[0] = c_OP_LDW;
      ops[1] = c_OP_SDW;
      ops[2] = c_OP_ADD;
      ops[3] = 6'h0D;

      rst_n = 1'b0; start = 1'b0; opcode = '0; addr = '0; wdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      check("reset.mem_we",    mem_we,    0);
      check("reset.mem_addr",  mem_addr,  0);
      check("reset.mem_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      idle(2);

      // Directed cases
      run_txn(c_OP_LDW, 32'h10, 32'h0,        0,           32'hDEADBEEF, 1'b0);
      run_txn(c_OP_SDW, 32'h20, 32'h12345678, 2,           32'hA5A5A5A5, 1'b0);
      run_txn(c_OP_LDW, 32'h13, 32'h0,        0,           32'h0,        1'b0);
      idle(2);
      run_txn(c_OP_SDW, 32'h30, 32'hCAFEF00D, TIMEOUT,     32'h0,        1'b0);
      run_txn(c_OP_LDW, 32'h34, 32'h0,        0,           32'h0BADC0DE, 1'b0);
      run_txn(c_OP_LDW, 32'h38, 32'h0,        TIMEOUT - 1, 32'h13572468, 1'b0);

      // Reset in the middle of an outstanding load
      start = 1'b1; opcode = c_OP_LDW; addr = 32'h40; wdata = '0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("rst.mem_req_before", mem_req, 1);
      rst_n = 1'b0;
      @(negedge clk);
      exp_rdata = '0;
      check_quiet("rst.mid");
      check("rst.mem_addr", mem_addr, 0);
      rst_n     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF0000;
      @(negedge clk);
      check_quiet("rst.late_ack");
      mem_ack = 1'b0;

      // Non-memory opcode, then a held LDW followed by a back-to-back LDW
      run_txn(c_OP_ADD, 32'h44, 32'h0,        0,           32'h0,        1'b0);
      run_txn(c_OP_LDW, 32'h48, 32'h0,        1,           32'h11112222, 1'b1);
      run_txn(c_OP_LDW, 32'h4C, 32'h0,        0,           32'h33334444, 1'b0);
      idle(1);

      // Randomised instruction stream
      for (int i = 0; i < 80; i++) begin
         ra = $urandom;
         if ($urandom_range(3) != 0) ra[1:0] = 2'b00;
         if (ops[i % 4] == c_OP_ADD || $urandom_range(3) == 0) begin
            run_txn(ops[$urandom_range(3)], ra, $urandom, $urandom_range(TIMEOUT + 1),
                    $urandom, 1'b0);
         end else begin
            run_txn(ops[$urandom_range(1)], ra, $urandom, $urandom_range(TIMEOUT + 1),
                    $urandom, 1'($urandom_range(1)) && (ra[1:0] == 2'b00));
         end
         if ($urandom_range(2) == 0) idle(1);
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer side of the load/store operand path: takes the effective address and rt store data produced for LDW/SDW, and performs the data-memory transaction.
- Drives a req/ack handshake toward data memory and stalls the pipeline while the access is outstanding.
- Returns the load data with a one-cycle done pulse.
- Sits between the execute stage (ALU result plus rt) and the data memory.

Parameters:
- ADDR_W, 32, width of the effective address and mem_addr.
- DATA_W, 32, width of store data and load data.
- TIMEOUT, 255, maximum cycles mem_req is held without mem_ack before the access is aborted (must be ≥1).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  execute stage presents a valid instruction this cycle.
- opcode  input  6  instruction opcode; only LDW and SDW cause an access.
- addr  input  ADDR_W  effective address (base + imm).
- wdata  input  DATA_W  store data (rt value).
- busy  output  1  stall request; high whenever state != IDLE.
- done  output  1  one-cycle pulse when an access completes successfully.
- rdata  output  DATA_W  load result; valid while done=1 and held until the next load completes.
- err  output  1  one-cycle pulse on a misaligned address or a timeout.
- mem_req  output  1  memory request, held until acknowledged.
- mem_we  output  1  1 = write (SDW), 0 = read (LDW).
- mem_addr  output  ADDR_W  latched word address.
- mem_wdata  output  DATA_W  latched store data.
- mem_rdata  input  DATA_W  memory read data; valid in the mem_ack cycle.
- mem_ack  input  1  memory completion; sampled only while mem_req=1.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; busy, done, err, mem_req, mem_we = 0.
  - mem_addr, mem_wdata, rdata = 0; timeout counter = 0.
  - Reset mid-access drops mem_req at that edge with no done or err; the memory side must tolerate the abandoned request.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - start=1, opcode∈{LDW,SDW}, addr[1:0]==0: latch addr, wdata and we=(opcode==SDW); go to ACCESS. mem_req=1 from the next cycle.
  - start=1, opcode∈{LDW,SDW}, addr[1:0]!=0: err=1 for exactly the next cycle, no request issued, stay IDLE, busy stays 0.
  - Other opcodes, or start=0: no action.
  - mem_ack in IDLE is ignored.
- ACCESS:
  - mem_req=1, with mem_addr, mem_we and mem_wdata held stable.
  - The counter increments each cycle without mem_ack.
  - mem_ack=1: if a load, capture mem_rdata into rdata at this edge; drop mem_req; go to DONE.
  - Counter reaches TIMEOUT with no ack: drop mem_req, err=1 for one cycle, go to IDLE. rdata is unchanged.
  - Ack takes priority over timeout if both occur in the same cycle.
- DONE:
  - done=1 for one cycle, busy=1, next state IDLE.
  - A start in DONE is not accepted; the stalled pipeline re-presents it.
- Latency:
  - start accepted at cycle T, mem_req first high at T+1.
  - Ack at T+1 gives done at T+2, busy=0 at T+3.
  - Each ack-wait cycle adds one cycle.
- start while busy=1 is ignored. The pipeline holds the instruction because of the stall.
- Counter width is clog2(TIMEOUT+1). It clears on entry to ACCESS.
- No arithmetic on addr; the address is passed through unmodified (byte address, word aligned).

Decomposition:
- LDW and SDW opcode values come from the shared def.v constants, never duplicated locally.
- FSM state encodings are local parameters of this module.
- One natural sub-module: access_timeout_counter.
  - Inputs: clk, rst_n, clear, enable.
  - Output: expired, high when count == TIMEOUT.
  - Parameterised by TIMEOUT.

Test Plan:
- Load, immediate ack: LDW, addr=0x10, mem_ack at T+1 with mem_rdata=0xDEADBEEF -> mem_req high T+1 only, mem_we=0, done at T+2, rdata=0xDEADBEEF, busy high T+1..T+2.
- Store, 3-cycle wait: SDW, addr=0x20, wdata=0x12345678, mem_ack at T+3 -> mem_req/mem_we/mem_addr/mem_wdata stable T+1..T+3, done at T+4, rdata unchanged.
- Misaligned: LDW, addr=0x13 -> err=1 at T+1 only, mem_req never asserted, busy=0 throughout.
- Timeout: TIMEOUT=4, SDW, no ack -> mem_req high for 4 cycles, then err pulse, done never asserted, back to IDLE; a following LDW with immediate ack completes normally.
- Reset mid-access: LDW, rst_n=0 at T+2 before ack -> at that edge mem_req=0, busy=0, no done/err; an ack arriving afterwards is ignored.
- Non-memory and back-to-back: ADD opcode with start=1 -> no request, busy=0; start held during busy is ignored; the second LDW is accepted only once busy=0.
